gf180mcu_fd_sc_mcu7t5v0__pwrseq_func: RTL

GF180MCU_FD_SC_MCU7T5V0__PWRSEQ_FUNC -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__pwrseq_func

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__pwrseq_pkg.sv | 10 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__pwrseq_cnt.sv | 19 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__pwrseq_func.sv | 115 +++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrseq_pkg.sv
// gf180mcu_fd_sc_mcu7t5v0__pwrseq_pkg: sequencer state encoding, default parameters, sizing helper
package gf180mcu_fd_sc_mcu7t5v0__pwrseq_pkg;
  localparam int DEF_NSEG = 4;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_TIMEOUT_CYC = 64;
  typedef enum logic [2:0] {ST_OFF, ST_RAMP, ST_ON, ST_DRAIN, ST_FAULT} state_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrseq_cnt.sv
// gf180mcu_fd_sc_mcu7t5v0__pwrseq_cnt: loadable settle/timeout down-counter that parks at zero
module gf180mcu_fd_sc_mcu7t5v0__pwrseq_cnt
  import gf180mcu_fd_sc_mcu7t5v0__pwrseq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rn_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // Load wins; otherwise count down and hold at zero, never wrapping
  always_comb cnt_d = ld_i ? ld_val_i : (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
  // Counter register, cleared by the synchronous reset
  always_ff @(posedge clk_i) cnt_q <= !rn_i ? '0 : cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrseq_func.sv
// gf180mcu_fd_sc_mcu7t5v0__pwrseq_func: segmented supply ramp/drain sequencer; ack timeout fault enabled by GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_TIMEOUT_EN
module gf180mcu_fd_sc_mcu7t5v0__pwrseq_func
  import gf180mcu_fd_sc_mcu7t5v0__pwrseq_pkg::*;
#(
  parameter int NSEG = DEF_NSEG,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic            CLK,
  input  logic            RN,
  inout  wire             VDD,
  inout  wire             VSS,
  input  logic            PWR_REQ,
  input  logic [NSEG-1:0] SEG_ACK,
  output logic [NSEG-1:0] SEG_EN,
  output logic            PWR_GOOD,
  output logic            BUSY,
  output logic            FAULT
);
  localparam int CW = $clog2(max_int(SETTLE_CYC, TIMEOUT_CYC) + 1);
  localparam int KW = max_int(1, $clog2(NSEG));
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [NSEG-1:0] seg_q, seg_d, bit_k;
  logic ld, cnt_zero, ack_ok, down;
  logic [CW-1:0] ld_val;
  wire unused_supply = VDD ^ VSS;
  gf180mcu_fd_sc_mcu7t5v0__pwrseq_cnt #(.W(CW)) u_cnt (
    .clk_i(CLK), .rn_i(RN), .ld_i(ld), .ld_val_i(ld_val), .zero_o(cnt_zero)
  );
  assign bit_k = NSEG'(1) << k_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_LD = CW'(TIMEOUT_CYC - 1);
  logic tmo_q, tmo_d;
  assign ack_ok = SEG_ACK[k_q] && (cnt_zero || tmo_q);
  assign FAULT = state_q == ST_FAULT;
  // Marks that the counter is running the ack timeout rather than the settle time
  always_ff @(posedge CLK) tmo_q <= !RN ? 1'b0 : tmo_d;
`else
  assign ack_ok = SEG_ACK[k_q] && cnt_zero;
  assign FAULT = 1'b0;
`endif
  // Next state: ramp one segment per settle+ack, drop the top segment per settle period when draining
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    seg_d = seg_q;
    ld = 1'b0;
    ld_val = SETTLE_LD;
    down = 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_TIMEOUT_EN
    tmo_d = tmo_q;
`endif
    case (state_q)
      ST_OFF: if (PWR_REQ) begin
        state_d = ST_RAMP;
        k_d = '0;
        seg_d = NSEG'(1);
        ld = 1'b1;
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_TIMEOUT_EN
        tmo_d = 1'b0;
`endif
      end
      ST_RAMP: begin
        if (!PWR_REQ) down = 1'b1;
        else if (ack_ok && k_q == KW'(NSEG - 1)) state_d = ST_ON;
        else if (ack_ok) begin
          k_d = k_q + 1'b1;
          seg_d = seg_q | (bit_k << 1);
          ld = 1'b1;
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_TIMEOUT_EN
          tmo_d = 1'b0;
`endif
        end
`ifdef GF180MCU_FD_SC_MCU7T5V0_PWRSEQ_TIMEOUT_EN
        else if (cnt_zero && !tmo_q) begin
          ld = 1'b1;
          ld_val = TMO_LD;
          tmo_d = 1'b1;
        end else if (cnt_zero) begin
          state_d = ST_FAULT;
          seg_d = '0;
          k_d = '0;
        end
`endif
      end
      ST_ON: down = !PWR_REQ;
      ST_DRAIN: down = cnt_zero;
      ST_FAULT: if (!PWR_REQ) state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase
    if (down) begin
      seg_d = seg_q & ~bit_k;
      k_d = k_q == '0 ? '0 : k_q - 1'b1;
      state_d = k_q == '0 ? ST_OFF : ST_DRAIN;
      ld = 1'b1;
    end
  end
  // State, index and enable registers; reset overrides every other event
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= ST_OFF;
      k_q <= '0;
      seg_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      seg_q <= seg_d;
    end
  end
  assign SEG_EN = seg_q;
  assign PWR_GOOD = state_q == ST_ON;
  assign BUSY = state_q == ST_RAMP || state_q == ST_DRAIN;
endmodule
